// File: rtl/mem_unit.sv
// mem_unit: CPU load/store unit with wait states, sub-word access, fault detection and optional MMIO.
// Ports: clk, reset (async active-low), req/we/size/unsigned_ld/addr/wdata (request, latched in IDLE),
//        ready/rdata/err (one-cycle response), busy (state != IDLE), mmio_out (MMIO output register).
// Optional feature: define MEM_UNIT_MMIO_EN for the mmio_out register at 0x8000 and the cycle counter at 0x8004.
module mem_unit #(
  parameter int WAIT_CYCLES = 1,
  parameter int DEPTH_WORDS = 8192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic [31:0] mmio_out
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] LAST = 3'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_we, r_u, r_ready, r_err;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [31:0] r_mem [DEPTH_WORDS];
  logic        w_idle, w_we, w_u, w_is_mmio, w_is_cnt, w_fault, w_enter, w_commit;
  logic [1:0]  w_size;
  logic [31:0] w_addr, w_wdata, w_wd, w_word, w_sh, w_ld;
  logic [3:0]  w_be;
  logic [AW-1:0] w_idx;
  // In IDLE the access is taken straight from the inputs so zero-wait and faulting accesses resolve on the accept edge.
  assign w_idle  = r_state == IDLE;
  assign w_we    = w_idle ? we : r_we;
  assign w_u     = w_idle ? unsigned_ld : r_u;
  assign w_size  = w_idle ? size : r_size;
  assign w_addr  = w_idle ? addr : r_addr;
  assign w_wdata = w_idle ? wdata : r_wdata;
  assign w_idx   = w_addr[AW+1:2];
  assign w_fault = (w_size == 2'b11) | (w_size == 2'b01 & w_addr[0]) | (w_size == 2'b10 & |w_addr[1:0]) |
                   (|w_addr[31:15] & ~(w_is_mmio | w_is_cnt)) | (w_we & w_is_cnt);
  assign w_enter = w_idle ? (req && (WAIT_CYCLES == 0 || w_fault)) : (r_state == WAIT && r_cnt == LAST);
  // Gated by reset so a store presented while reset is low never reaches RAM.
  assign w_commit = reset & w_enter & ~w_fault;
  assign w_be = w_size == 2'b00 ? 4'b0001 << w_addr[1:0] : w_size == 2'b01 ? (w_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wd = w_size == 2'b00 ? {4{w_wdata[7:0]}} : w_size == 2'b01 ? {2{w_wdata[15:0]}} : w_wdata;
  assign w_sh = w_word >> {w_addr[1:0], 3'b000};
  assign w_ld = w_size == 2'b00 ? {{24{~w_u & w_sh[7]}}, w_sh[7:0]} :
                w_size == 2'b01 ? {{16{~w_u & w_sh[15]}}, w_sh[15:0]} : w_word;
`ifdef MEM_UNIT_MMIO_EN
  logic [31:0] r_mmio, r_cyc;
  assign w_is_mmio = w_addr[31:2] == 30'h2000;
  assign w_is_cnt  = w_addr[31:2] == 30'h2001;
  assign w_word    = w_is_mmio ? r_mmio : w_is_cnt ? r_cyc : r_mem[w_idx];
  assign mmio_out  = r_mmio;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_mmio <= '0;
      r_cyc  <= '0;
    end else begin
      r_cyc <= r_cyc + 32'd1;
      if (w_commit && w_we && w_is_mmio)
        for (int i = 0; i < 4; i++)
          if (w_be[i]) r_mmio[8*i +: 8] <= w_wd[8*i +: 8];
    end
`else
  assign w_is_mmio = 1'b0;
  assign w_is_cnt  = 1'b0;
  assign w_word    = r_mem[w_idx];
  assign mmio_out  = '0;
`endif
  always_ff @(posedge clk)
    if (w_commit && w_we && !w_is_mmio)
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_u     <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= w_enter;
      r_err   <= w_enter & w_fault;
      r_rdata <= (w_enter && !w_fault && !w_we) ? w_ld : '0;
      case (r_state)
        IDLE: if (req) begin
          r_we    <= we;
          r_u     <= unsigned_ld;
          r_size  <= size;
          r_addr  <= addr;
          r_wdata <= wdata;
          r_cnt   <= '0;
          r_state <= w_enter ? RESP : WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt + 3'd1;
          if (w_enter) r_state <= RESP;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign ready = r_ready;
  assign err   = r_err;
  assign rdata = r_rdata;
  assign busy  = r_state != IDLE;
endmodule

// File: tb/tb_mem_unit.sv
// tb_mem_unit: self-checking bench for mem_unit against a byte-level reference model.
module tb_mem_unit;
  localparam int WC = 1;
  logic clk = 0, reset = 0, req = 0, req1 = 0, we = 0, unsigned_ld = 0;
  logic [1:0] size = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic ready, err, busy, ready1, err1, busy1;
  logic [31:0] rdata, mmio_out, rdata1, mmio_out1;
  int errors = 0, checks = 0, cyc = 0;
  logic [31:0] model [int];
  logic [31:0] mmio_m = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mem_unit #(.WAIT_CYCLES(WC)) u0 (.clk(clk), .reset(reset), .req(req), .we(we), .size(size),
    .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata), .ready(ready), .rdata(rdata), .err(err),
    .busy(busy), .mmio_out(mmio_out));
  mem_unit #(.WAIT_CYCLES(0)) u1 (.clk(clk), .reset(reset), .req(req1), .we(we), .size(size),
    .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata), .ready(ready1), .rdata(rdata1), .err(err1),
    .busy(busy1), .mmio_out(mmio_out1));
  function automatic logic is_mmio(input logic [31:0] a);
`ifdef MEM_UNIT_MMIO_EN
    return (a >> 2) == 32'h2000;
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic is_cnt(input logic [31:0] a);
`ifdef MEM_UNIT_MMIO_EN
    return (a >> 2) == 32'h2001;
`else
    return 1'b0;
`endif
  endfunction
  function automatic int nbytes(input logic [1:0] s);
    return s == 0 ? 1 : s == 1 ? 2 : 4;
  endfunction
  function automatic logic fault_of(input logic w, input logic [1:0] s, input logic [31:0] a);
    if (s == 3) return 1'b1;
    if (s == 1 && a % 2 != 0) return 1'b1;
    if (s == 2 && a % 4 != 0) return 1'b1;
    if (a >= 32'h8000 && !is_mmio(a) && !is_cnt(a)) return 1'b1;
    return w && is_cnt(a);
  endfunction
  function automatic void model_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    int key = int'(a >> 2);
    int off = int'(a % 4);
    logic [31:0] word;
    word = is_mmio(a) ? mmio_m : model.exists(key) ? model[key] : 32'h0;
    for (int k = 0; k < nbytes(s); k++) word[8*(off+k) +: 8] = d[8*k +: 8];
    if (is_mmio(a)) mmio_m = word;
    else model[key] = word;
  endfunction
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s, input logic u);
    int off = int'(a % 4);
    int nb = nbytes(s);
    logic [31:0] word, v;
    word = is_mmio(a) ? mmio_m : model[int'(a >> 2)];
    v = 0;
    for (int k = 0; k < nb; k++) v[8*k +: 8] = word[8*(off+k) +: 8];
    if (!u && nb < 4 && v[8*nb-1])
      for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hff;
    return v;
  endfunction
  task automatic access(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rd, output logic e, output int at);
    @(negedge clk);
    req = 1; we = w; size = s; unsigned_ld = u; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 0; at = cyc; lat = 1;
    we = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
    while (ready !== 1'b1 && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rdata; e = err;
    @(posedge clk); #1;
  endtask
  task automatic test_reset;
    #1;
    checks++; if ({ready, err, busy, rdata, mmio_out} !== 67'h0) begin errors++; $display("FAIL reset_outputs got %h want 0", {ready, err, busy, rdata, mmio_out}); end
    checks++; if ({ready1, err1, busy1, rdata1} !== 35'h0) begin errors++; $display("FAIL reset_outputs_u1 got %h want 0", {ready1, err1, busy1, rdata1}); end
    repeat (2) @(negedge clk);
    reset = 1;
  endtask
  task automatic test_word;
    int lat, at; logic [31:0] rd; logic e;
    access(1, 2, 0, 32'h100, 32'hDEADBEEF, lat, rd, e, at);
    model_store(32'h100, 2, 32'hDEADBEEF);
    checks++; if (lat !== WC + 1 || e !== 0) begin errors++; $display("FAIL sw_latency got lat=%0d err=%b want lat=%0d err=0", lat, e, WC + 1); end
    access(0, 2, 0, 32'h100, 0, lat, rd, e, at);
    checks++; if (lat !== WC + 1) begin errors++; $display("FAIL lw_latency got %0d want %0d", lat, WC + 1); end
    checks++; if (rd !== 32'hDEADBEEF || e !== 0) begin errors++; $display("FAIL lw_data got %h err=%b want deadbeef err=0", rd, e); end
  endtask
  task automatic test_byte;
    int lat, at; logic [31:0] rd; logic e;
    access(1, 0, 0, 32'h101, 32'h80, lat, rd, e, at);
    model_store(32'h101, 0, 32'h80);
    access(0, 0, 0, 32'h101, 0, lat, rd, e, at);
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb got %h want ffffff80", rd); end
    access(0, 0, 1, 32'h101, 0, lat, rd, e, at);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu got %h want 00000080", rd); end
    access(0, 2, 0, 32'h100, 0, lat, rd, e, at);
    checks++; if (rd !== 32'hDEAD80EF) begin errors++; $display("FAIL byte_lanes got %h want dead80ef", rd); end
  endtask
  task automatic test_faults;
    int lat, at; logic [31:0] rd; logic e;
    access(0, 1, 0, 32'h103, 0, lat, rd, e, at);
    checks++; if (lat !== 1 || e !== 1 || rd !== 0) begin errors++; $display("FAIL lh_misaligned got lat=%0d err=%b rdata=%h want 1 1 0", lat, e, rd); end
    access(1, 2, 0, 32'h102, 32'h11223344, lat, rd, e, at);
    checks++; if (lat !== 1 || e !== 1) begin errors++; $display("FAIL sw_misaligned got lat=%0d err=%b want 1 1", lat, e); end
    access(1, 3, 0, 32'h100, 32'h55667788, lat, rd, e, at);
    checks++; if (lat !== 1 || e !== 1 || rd !== 0) begin errors++; $display("FAIL size11 got lat=%0d err=%b rdata=%h want 1 1 0", lat, e, rd); end
    access(0, 2, 0, 32'h100, 0, lat, rd, e, at);
    checks++; if (rd !== 32'hDEAD80EF || e !== 0) begin errors++; $display("FAIL fault_no_write got %h want dead80ef", rd); end
  endtask
  task automatic test_reset_mid;
    int lat, at; logic [31:0] rd; logic e;
    access(1, 2, 0, 32'h200, 32'h11111111, lat, rd, e, at);
    model_store(32'h200, 2, 32'h11111111);
    @(negedge clk);
    req = 1; we = 1; size = 2; unsigned_ld = 0; addr = 32'h200; wdata = 32'h12345678;
    @(posedge clk); #1;
    req = 0;
    checks++; if (busy !== 1) begin errors++; $display("FAIL busy_in_wait got %b want 1", busy); end
    reset = 0; #1;
    checks++; if (busy !== 0 || ready !== 0 || mmio_out !== 0) begin errors++; $display("FAIL async_reset got busy=%b ready=%b mmio=%h want 0", busy, ready, mmio_out); end
    @(negedge clk); @(negedge clk);
    reset = 1; mmio_m = 0;
    access(0, 2, 0, 32'h200, 0, lat, rd, e, at);
    checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL discarded_store got %h want 11111111", rd); end
  endtask
  task automatic test_mmio;
    int lat, at, at2; logic [31:0] rd, rd2; logic e;
    access(1, 2, 0, 32'h8000, 32'hA5, lat, rd, e, at);
`ifdef MEM_UNIT_MMIO_EN
    mmio_m = 32'hA5;
    checks++; if (e !== 0 || mmio_out !== 32'hA5) begin errors++; $display("FAIL mmio_store got err=%b mmio=%h want 0 000000a5", e, mmio_out); end
    access(1, 2, 0, 32'h8004, 32'h5, lat, rd, e, at);
    checks++; if (e !== 1) begin errors++; $display("FAIL counter_store got err=%b want 1", e); end
    access(0, 2, 0, 32'h8004, 0, lat, rd, e, at);
    repeat ($urandom_range(1, 20)) @(posedge clk);
    access(0, 2, 0, 32'h8004, 0, lat, rd2, e, at2);
    checks++; if (rd2 - rd !== 32'(at2 - at)) begin errors++; $display("FAIL counter_delta got %0d want %0d", rd2 - rd, at2 - at); end
`else
    checks++; if (e !== 1 || mmio_out !== 0) begin errors++; $display("FAIL mmio_disabled got err=%b mmio=%h want 1 0", e, mmio_out); end
`endif
  endtask
  task automatic test_back_to_back;
    @(negedge clk);
    we = 1; size = 2; unsigned_ld = 0; addr = 32'h300; wdata = 32'hCAFEF00D; req1 = 1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      checks++; if (ready1 !== 1'(k % 2) || busy1 !== 1'(k % 2)) begin errors++; $display("FAIL b2b_cycle%0d got ready=%b busy=%b want %0d", k, ready1, busy1, k % 2); end
    end
    @(negedge clk);
    req1 = 0;
    @(negedge clk);
    we = 0; req1 = 1;
    @(posedge clk); #1;
    req1 = 0;
    checks++; if (ready1 !== 1 || rdata1 !== 32'hCAFEF00D || err1 !== 0) begin errors++; $display("FAIL b2b_load got ready=%b rdata=%h want 1 cafef00d", ready1, rdata1); end
    @(posedge clk); #1;
  endtask
  task automatic test_random;
    int lat, at, r; logic w, u, f, e; logic [1:0] s; logic [31:0] a, d, rd, exp;
    for (int i = 0; i < 16; i++) begin
      a = 32'h100 + 4 * i; d = $urandom;
      access(1, 2, 0, a, d, lat, rd, e, at);
      model_store(a, 2, d);
      checks++; if (e !== 0 || lat !== WC + 1) begin errors++; $display("FAIL init_store%0d got err=%b lat=%0d", i, e, lat); end
    end
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9); w = 1'($urandom); u = 1'($urandom); s = 2'($urandom); d = $urandom;
      a = r < 7 ? 32'h100 + $urandom_range(0, 63) : r == 7 ? ($urandom | 32'h8000) : 32'h8000 + $urandom_range(0, 7);
      if (is_cnt(a)) w = 1;
      f = fault_of(w, s, a);
      exp = (!f && !w) ? model_load(a, s, u) : 32'h0;
      access(w, s, u, a, d, lat, rd, e, at);
      if (!f && w) model_store(a, s, d);
      checks++; if (lat !== (f ? 1 : WC + 1)) begin errors++; $display("FAIL rnd%0d_latency a=%h got %0d want %0d", i, a, lat, f ? 1 : WC + 1); end
      checks++; if (e !== f) begin errors++; $display("FAIL rnd%0d_err a=%h s=%0d got %b want %b", i, a, s, e, f); end
      checks++; if (rd !== exp) begin errors++; $display("FAIL rnd%0d_rdata a=%h s=%0d u=%b got %h want %h", i, a, s, u, rd, exp); end
      checks++; if (mmio_out !== mmio_m) begin errors++; $display("FAIL rnd%0d_mmio got %h want %h", i, mmio_out, mmio_m); end
      checks++; if ({ready, err, rdata} !== 34'h0) begin errors++; $display("FAIL rnd%0d_idle_outputs got %h want 0", i, {ready, err, rdata}); end
    end
  endtask
  initial begin
    test_reset;
    test_word;
    test_byte;
    test_faults;
    test_reset_mid;
    test_mmio;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_unit.md
MEM_UNIT -- requirements
Module: mem_unit

Interface
REQ-001 Parameter: WAIT_CYCLES, default 1, memory wait states inserted per access; legal range 0..7.
REQ-002 Parameter: DEPTH_WORDS, default 8192, RAM depth in 32-bit words; word index = addr[14:2].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  CPU access request; sampled only in IDLE.
REQ-006 we  input  1  1 = store, 0 = load.
REQ-007 size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 unsigned_ld  input  1  1 = zero-extend load data, 0 = sign-extend.
REQ-009 addr  input  32  byte address.
REQ-010 wdata  input  32  store data, right-aligned.
REQ-011 ready  output  1  one-cycle response strobe.
REQ-012 rdata  output  32  extended load data; valid only while ready=1.
REQ-013 err  output  1  access fault; valid only while ready=1.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 mmio_out  output  32  memory-mapped output register.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, RESP.
REQ-017 IDLE with req=1: latch we, size, unsigned_ld, addr, wdata; go to WAIT, or to RESP if WAIT_CYCLES=0 or the access faults.
REQ-018 WAIT: count WAIT_CYCLES cycles, then go to RESP; inputs are ignored.
REQ-019 RAM read/write commits on the edge entering RESP; ready=1 for exactly one cycle in RESP; RESP always returns to IDLE.
REQ-020 Latency: ready rises WAIT_CYCLES+1 cycles after the accepting edge; a faulting access responds 1 cycle after accept.
REQ-021 req held high during RESP is not accepted until the following IDLE cycle; back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
REQ-022 Fault conditions: size=11; halfword with addr[0]=1; word with addr[1:0]!=0; addr[31:15]!=0 outside the MMIO window.
REQ-023 On fault: err=1, rdata=0, no RAM or MMIO write.
REQ-024 Stores: byte write enables lane addr[1:0] with wdata[7:0]; halfword enables lanes {addr[1],x} with wdata[15:0]; word writes all lanes; unselected lanes are unchanged.
REQ-025 Loads: extract the selected byte or halfword, then sign- or zero-extend to 32 bits per unsigned_ld; word loads are returned unmodified.
REQ-026 ready=0 forces rdata=0 and err=0.

Reset
REQ-027 reset low SHALL immediately force state IDLE, wait counter 0, ready=0, err=0, rdata=0, busy=0, mmio_out=0.
REQ-028 Reset asserted mid-access SHALL discard the access; an uncommitted store never reaches RAM.
REQ-029 RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-030 Macro MEM_UNIT_MMIO_EN defined: word address 0x0000_8000 is the mmio_out register (store writes it with byte enables; load returns it); word address 0x0000_8004 is a read-only free-running 32-bit cycle counter that is reset to 0 and wraps modulo 2^32; a store to 0x8004 faults.
REQ-031 Macro undefined: both addresses fault per REQ-022, mmio_out is tied to 0, and no counter logic is synthesised.

Verification
REQ-032 WAIT_CYCLES=1: word store 0xDEADBEEF to 0x100, then word load from 0x100 -> ready 2 cycles after each accept, rdata=0xDEADBEEF, err=0.
REQ-033 Byte store 0x80 to 0x101, then lb and lbu from 0x101 -> rdata 0xFFFFFF80 and 0x00000080; other bytes of word 0x100 are unchanged (0xDEAD80EF).
REQ-034 Halfword load from 0x103; word store to 0x102; size=11 -> err=1 one cycle after accept, RAM unchanged.
REQ-035 Reset pulled low during WAIT of a store of 0x12345678 to 0x200 -> busy=0 immediately; a later load from 0x200 returns the prior value.
REQ-036 MEM_UNIT_MMIO_EN defined: store 0xA5 to 0x8000 -> mmio_out=0x000000A5; two loads from 0x8004 N cycles apart differ by N. Macro undefined: the same store -> err=1 and mmio_out=0.
REQ-037 req held high continuously with WAIT_CYCLES=0 -> ready pulses every 2nd cycle and busy toggles accordingly.
